// File: rtl/vldst_if.sv
// Memory request/return channel and vector register file ports of the vector
// load/store unit. The unit is the master; memory and register file are the slave.
interface vldst_if;
  logic         mem_req;
  logic         mem_we;
  logic [15:0]  mem_addr;
  logic [15:0]  mem_wdata;
  logic         mem_ready;
  logic         mem_rvalid;
  logic [15:0]  mem_rdata;
  logic [3:0]   vr_raddr;
  logic [255:0] vr_rdata;
  logic [3:0]   vr_rlen;
  logic         vr_wen;
  logic [3:0]   vr_waddr;
  logic [3:0]   vr_wlen;
  logic [255:0] vr_wdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output vr_raddr,
    input  vr_rdata, vr_rlen,
    output vr_wen, vr_waddr, vr_wlen, vr_wdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  vr_raddr,
    output vr_rdata, vr_rlen,
    input  vr_wen, vr_waddr, vr_wlen, vr_wdata
  );
endinterface

// File: rtl/vldst.sv
// Vector load/store unit: moves 16 x 16-bit element vectors between a vector
// register file and a 16-bit element-addressed memory, one element per request.
module vldst (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [3:0]  vreg,
  input  logic [15:0] base,
  input  logic [3:0]  len,
  output logic        busy,
  output logic        done,
  vldst_if.master     bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LD_REQ  = 3'd1;
  localparam logic [2:0] LD_WB   = 3'd2;
  localparam logic [2:0] ST_RD   = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;
  localparam logic [2:0] ST_REQ  = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [3:0]  vreg_q;
  logic [15:0] base_q;
  logic [3:0]  cnt_q;
  logic [4:0]  iss_q;
  logic [4:0]  ret_q;
  logic [15:0] elem_q [16];

  logic accept;
  logic ld_ret;
  logic last_ret;
  logic ld_issuing;

  assign ld_issuing = (state_q == LD_REQ) && (iss_q <= {1'b0, cnt_q});
  assign accept     = bus.mem_req && bus.mem_ready;
  // Returns are only meaningful while a load still expects data; stray ones are dropped.
  assign ld_ret     = (state_q == LD_REQ) && bus.mem_rvalid && (ret_q <= {1'b0, cnt_q});
  assign last_ret   = ld_ret && (ret_q[3:0] == cnt_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = op ? ST_RD : LD_REQ;
      LD_REQ:  if (last_ret) state_d = LD_WB;
      LD_WB:   state_d = DONE;
      ST_RD:   state_d = ST_WAIT;
      ST_WAIT: state_d = ST_REQ;
      ST_REQ:  if (accept && (iss_q[3:0] == cnt_q)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vreg_q  <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      iss_q   <= '0;
      ret_q   <= '0;
      for (int unsigned i = 0; i < 16; i++) elem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            vreg_q <= vreg;
            base_q <= base;
            cnt_q  <= len;
            iss_q  <= '0;
            ret_q  <= '0;
            for (int unsigned i = 0; i < 16; i++) elem_q[i] <= '0;
          end
        end
        LD_REQ: begin
          if (accept) iss_q <= iss_q + 5'd1;
          if (ld_ret) begin
            elem_q[ret_q[3:0]] <= bus.mem_rdata;
            ret_q              <= ret_q + 5'd1;
          end
        end
        ST_WAIT: begin
          // For stores the element count comes from the register's stored length.
          cnt_q <= bus.vr_rlen;
          for (int unsigned i = 0; i < 16; i++) elem_q[i] <= bus.vr_rdata[16*i +: 16];
        end
        ST_REQ: begin
          if (accept) iss_q <= iss_q + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  assign bus.mem_req   = ld_issuing || (state_q == ST_REQ);
  assign bus.mem_we    = (state_q == ST_REQ);
  assign bus.mem_addr  = bus.mem_req ? (base_q + {11'b0, iss_q}) : '0;
  assign bus.mem_wdata = (state_q == ST_REQ) ? elem_q[iss_q[3:0]] : '0;

  assign bus.vr_raddr  = (state_q == ST_RD) ? vreg_q : '0;
  assign bus.vr_wen    = (state_q == LD_WB);
  assign bus.vr_waddr  = (state_q == LD_WB) ? vreg_q : '0;
  assign bus.vr_wlen   = (state_q == LD_WB) ? cnt_q : '0;

  always_comb begin
    bus.vr_wdata = '0;
    if (state_q == LD_WB) begin
      for (int unsigned i = 0; i < 16; i++) bus.vr_wdata[16*i +: 16] = elem_q[i];
    end
  end

endmodule

// File: tb/tb_vldst.sv
// Directed bench for vldst: memory/regfile responder with request and vreg-write
// scoreboards filled when each command is issued.
module tb_vldst;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op    = 1'b0;
  logic [3:0]  vreg  = '0;
  logic [15:0] base  = '0;
  logic [3:0]  len   = '0;
  logic        busy;
  logic        done;

  vldst_if bus ();

  vldst dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .vreg  (vreg),
    .base  (base),
    .len   (len),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] data;
  } req_t;

  typedef struct {
    logic [3:0]   waddr;
    logic [3:0]   wlen;
    logic [255:0] wdata;
  } vw_t;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_acc    = 0;
  int done_cyc    = 0;
  int wen_cnt     = 0;
  int rets        = 0;
  bit toggle_ready = 1'b0;

  req_t         exp_req [$];
  vw_t          exp_vw  [$];
  logic [15:0]  pend    [$];
  logic [255:0] regs    [16];
  logic [3:0]   rlens   [16];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    if (a >= 16'h0100 && a <= 16'h010F) return 16'h00A0 + (a - 16'h0100);
    return a ^ 16'h5A5A;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory and register-file responder plus output scoreboard, acting on the falling edge.
  initial begin
    logic [255:0] lat_d;
    logic [3:0]   lat_l;
    bit           stalled;
    logic [15:0]  st_addr, st_wdata;
    logic         st_we;
    req_t         e;
    vw_t          w;
    lat_d = '0; lat_l = '0; stalled = 1'b0;
    st_addr = '0; st_wdata = '0; st_we = 1'b0;
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    bus.vr_rdata   = '0;
    bus.vr_rlen    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend.delete();
        exp_req.delete();
        exp_vw.delete();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        chk("stall_req",   bus.mem_req,   1'b1);
        chk("stall_addr",  bus.mem_addr,  st_addr);
        chk("stall_we",    bus.mem_we,    st_we);
        chk("stall_wdata", bus.mem_wdata, st_wdata);
      end
      if (bus.vr_wen) begin
        wen_cnt++;
        chk("vr_wen_expected", 256'(exp_vw.size() != 0), 256'(1));
        if (exp_vw.size() != 0) begin
          w = exp_vw.pop_front();
          chk("vr_waddr", bus.vr_waddr, w.waddr);
          chk("vr_wlen",  bus.vr_wlen,  w.wlen);
          chk("vr_wdata", bus.vr_wdata, w.wdata);
        end
        regs[bus.vr_waddr]  = bus.vr_wdata;
        rlens[bus.vr_waddr] = bus.vr_wlen;
      end
      bus.vr_rdata = lat_d;
      bus.vr_rlen  = lat_l;
      lat_d = regs[bus.vr_raddr];
      lat_l = rlens[bus.vr_raddr];
      if (pend.size() != 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = pend.pop_front();
        rets++;
      end else begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
      end
      bus.mem_ready = toggle_ready ? ~bus.mem_ready : 1'b1;
      stalled  = bus.mem_req && !bus.mem_ready;
      st_addr  = bus.mem_addr;
      st_wdata = bus.mem_wdata;
      st_we    = bus.mem_we;
      if (bus.mem_req && bus.mem_ready) begin
        last_acc = cyc + 1;
        chk("req_expected", 256'(exp_req.size() != 0), 256'(1));
        if (exp_req.size() != 0) begin
          e = exp_req.pop_front();
          chk("mem_addr", bus.mem_addr, e.addr);
          chk("mem_we",   bus.mem_we,   e.we);
          if (e.we) chk("mem_wdata", bus.mem_wdata, e.data);
        end
        if (!bus.mem_we) pend.push_back(mem_val(bus.mem_addr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},     busy,          1'b0);
    chk({tag, "_done"},     done,          1'b0);
    chk({tag, "_mem_req"},  bus.mem_req,   1'b0);
    chk({tag, "_mem_we"},   bus.mem_we,    1'b0);
    chk({tag, "_mem_addr"}, bus.mem_addr,  16'h0);
    chk({tag, "_mem_wd"},   bus.mem_wdata, 16'h0);
    chk({tag, "_vr_raddr"}, bus.vr_raddr,  4'h0);
    chk({tag, "_vr_wen"},   bus.vr_wen,    1'b0);
    chk({tag, "_vr_waddr"}, bus.vr_waddr,  4'h0);
    chk({tag, "_vr_wlen"},  bus.vr_wlen,   4'h0);
    chk({tag, "_vr_wdata"}, bus.vr_wdata,  256'h0);
  endtask

  task automatic issue(input logic o, input logic [3:0] vr, input logic [15:0] b, input logic [3:0] l);
    req_t         r;
    vw_t          w;
    logic [255:0] d;
    int           n;
    if (!o) begin
      d = '0;
      for (int i = 0; i <= int'(l); i++) begin
        r.addr = b + 16'(i); r.we = 1'b0; r.data = '0;
        exp_req.push_back(r);
        d[16*i +: 16] = mem_val(b + 16'(i));
      end
      w.waddr = vr; w.wlen = l; w.wdata = d;
      exp_vw.push_back(w);
    end else begin
      n = int'(rlens[vr]);
      d = regs[vr];
      for (int k = 0; k <= n; k++) begin
        r.addr = b + 16'(k); r.we = 1'b1; r.data = d[16*k +: 16];
        exp_req.push_back(r);
      end
    end
    start = 1'b1; op = o; vreg = vr; base = b; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done) begin
        got = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    chk({tag, "_done_seen"}, got, 1'b1);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_idle"},       busy, 1'b0);
  endtask

  task automatic run_cmd(input string tag, input logic o, input logic [3:0] vr,
                         input logic [15:0] b, input logic [3:0] l, input bit poke);
    int wen0;
    wen0 = wen_cnt;
    issue(o, vr, b, l);
    chk({tag, "_busy"}, busy, 1'b1);
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1; op = ~o; vreg = 4'd5; base = 16'h5000; len = 4'd9;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done(tag, 300);
    if (o) chk({tag, "_done_after_last_acc"}, 32'(done_cyc), 32'(last_acc));
    chk({tag, "_reqs_left"}, 32'(exp_req.size()), 32'd0);
    chk({tag, "_vw_left"},   32'(exp_vw.size()),  32'd0);
    chk({tag, "_wen_count"}, 32'(wen_cnt - wen0), o ? 32'd0 : 32'd1);
    if (poke) begin
      repeat (8) @(posedge clk);
      #1;
      chk({tag, "_no_second_cmd"}, busy, 1'b0);
    end
  endtask

  initial begin
    int  rets0, wen0;
    bit  reached;
    for (int i = 0; i < 16; i++) begin
      regs[i]  = '0;
      rlens[i] = '0;
    end
    for (int i = 0; i < 16; i++) regs[5][16*i +: 16] = 16'h0010 + 16'(i);
    rlens[5] = 4'd15;

    #2;
    check_reset_outputs("rst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_cmd("ld_basic",  1'b0, 4'd3, 16'h0100, 4'd3,  1'b0);
    chk("ld_basic_reg", regs[3], {192'h0, 64'h00A3_00A2_00A1_00A0});
    run_cmd("ld_wrap",   1'b0, 4'd1, 16'hFFFE, 4'd3,  1'b0);
    run_cmd("st_full",   1'b1, 4'd5, 16'h2000, 4'd0,  1'b0);
    run_cmd("ld_len0",   1'b0, 4'd2, 16'h0105, 4'd0,  1'b0);
    chk("ld_len0_reg", regs[2], {240'h0, 16'h00A5});
    run_cmd("ld_len15",  1'b0, 4'd7, 16'h3000, 4'd15, 1'b0);
    run_cmd("st_len3",   1'b1, 4'd3, 16'h4000, 4'd0,  1'b0);

    toggle_ready = 1'b1;
    run_cmd("ld_stall",  1'b0, 4'd3, 16'h0100, 4'd3,  1'b0);
    chk("ld_stall_reg", regs[3], {192'h0, 64'h00A3_00A2_00A1_00A0});
    run_cmd("st_stall",  1'b1, 4'd5, 16'h2000, 4'd0,  1'b0);
    toggle_ready = 1'b0;

    run_cmd("ld_poke",   1'b0, 4'd4, 16'h0100, 4'd2,  1'b1);

    rets0 = rets;
    wen0  = wen_cnt;
    issue(1'b0, 4'd8, 16'h0200, 4'd7);
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (rets - rets0 >= 2) begin
        reached = 1'b1;
        break;
      end
    end
    chk("abort_two_returns", reached, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_wen",  32'(wen_cnt - wen0), 32'd0);
    chk("abort_idle",    busy,        1'b0);
    chk("abort_no_req",  bus.mem_req, 1'b0);

    run_cmd("ld_after_rst", 1'b0, 4'd6, 16'h0108, 4'd5, 1'b0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vldst.md
VLDST -- requirements
Module: vldst

Interface
REQ-001 Parameter: none; element width is fixed at 16 bits, 16 elements per vector, and vector width is 256 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  command strobe; sampled only in IDLE.
REQ-005 op  input  1  command type: 0 = load (memory to vreg), 1 = store (vreg to memory).
REQ-006 vreg  input  4  target or source vector register index.
REQ-007 base  input  16  element address in memory of element 0.
REQ-008 len  input  4  load element count minus 1 (0..15 means 1..16 elements); ignored for store.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 mem_req / mem_we / mem_addr / mem_wdata  output  1/1/16/16  memory request channel.
REQ-012 mem_ready  input  1  a request is accepted on a cycle where mem_req and mem_ready are both high.
REQ-013 mem_rvalid / mem_rdata  input  1/16  read return channel; returns arrive in order, at least 1 cycle after acceptance, with no backpressure.
REQ-014 vr_raddr  output  4  vreg read address; the register file registers it, so vr_rdata/vr_rlen are valid the cycle after.
REQ-015 vr_rdata / vr_rlen  input  256/4  vreg read data and stored length (count minus 1).
REQ-016 vr_wen / vr_waddr / vr_wlen / vr_wdata  output  1/4/4/256  vreg write port; the write lands at the next edge.

Function
REQ-017 Element i shall occupy bits [16i+15:16i] of any 256-bit vector.
REQ-018 States shall be IDLE, LD_REQ, LD_WB, ST_RD, ST_WAIT, ST_REQ, and DONE.
REQ-019 In IDLE with start=1, the block shall latch vreg, base, and len, then go to LD_REQ if op=0 or to ST_RD if op=1.
REQ-020 Any start asserted outside IDLE shall be ignored.
REQ-021 LD_REQ shall drive mem_req=1 and mem_we=0 with mem_addr = base + issue count (16-bit wrap) until len+1 requests have been accepted.
REQ-022 In LD_REQ, mem_req shall stay high with a stable address while mem_ready=0.
REQ-023 Each mem_rvalid during a load shall write mem_rdata into element slot = return count, then increment the return count.
REQ-024 The load buffer shall be zeroed at command acceptance, so elements above len read as 0.
REQ-025 The block shall move to LD_WB in the cycle after the (len+1)th return.
REQ-026 If that return coincides with the final request acceptance, the block shall still move to LD_WB only after the return count reaches len+1.
REQ-027 LD_WB shall hold vr_wen=1 for exactly one cycle with vr_waddr=vreg, vr_wlen=len, and vr_wdata equal to the buffer, then go to DONE.
REQ-028 ST_RD shall drive vr_raddr=vreg for one cycle, then go to ST_WAIT.
REQ-029 ST_WAIT shall capture vr_rdata into the buffer and vr_rlen into the count register, then go to ST_REQ.
REQ-030 ST_REQ shall drive mem_req=1, mem_we=1, mem_addr = base+k, and mem_wdata = element k, for k = 0..count.
REQ-031 In ST_REQ, k shall advance only on acceptance; after accepting k=count, the block shall go to DONE.
REQ-032 DONE shall assert done=1 for one cycle, then return to IDLE.
REQ-033 mem_rvalid outside a load shall be ignored.
REQ-034 vr_wen shall be 0 in every state except LD_WB.
REQ-035 mem_req shall be 0 in every state except LD_REQ and ST_REQ.

Reset
REQ-036 When rst_n=0, the block shall go to IDLE, clear all counters, and clear the buffer.
REQ-037 When rst_n=0, busy, done, mem_req, mem_we, and vr_wen shall be 0, and mem_addr, mem_wdata, vr_raddr, vr_waddr, vr_wlen, and vr_wdata shall all be 0.
REQ-038 A reset mid-command shall abort the command with no vreg write and no further memory requests.
REQ-039 After reset is released, the first start shall be accepted normally.

Verification
REQ-040 Load: op=0, vreg=3, base=0x0100, len=3, mem_ready=1, returns 0xA0..0xA3 one cycle after each request. Required: addresses 0x0100..0x0103; one vr_wen with waddr=3, wlen=3, wdata low 64 bits = 0x00A3_00A2_00A1_00A0 and upper bits 0; then done.
REQ-041 Load with wrap: base=0xFFFE, len=3. Required: addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-042 Store: vreg 5 holds elements 0x0010..0x001F with stored length 15; op=1, base=0x2000. Required: vr_raddr=5; 16 writes to 0x2000..0x200F with wdata 0x0010..0x001F; done 1 cycle after the last acceptance.
REQ-043 Backpressure: mem_ready toggles 0/1 during a load and during a store. Required: addr/wdata stay stable while stalled, no element is duplicated or dropped, and the final vreg contents and memory writes are identical to the no-stall run.
REQ-044 start pulsed while busy. Required: ignored, no second command executes.
REQ-045 rst_n asserted after two load returns. Required: no vr_wen, outputs at reset values; a subsequent load completes correctly.
